// File: rtl/wb_arb_pkg.sv
// Shared types for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGranted,
    StTimeout
  } wb_arb_state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick: rotate so the search starts at last+1,
// take the lowest set bit, then un-rotate back to a master index.
module wb_rr_pick #(
  parameter int unsigned MASTER_COUNT = 2,
  parameter int unsigned GNT_WIDTH    = $clog2(MASTER_COUNT)
) (
  input  logic [MASTER_COUNT-1:0] eligible_i,
  input  logic [GNT_WIDTH-1:0]    last_i,
  output logic                    valid_o,
  output logic [GNT_WIDTH-1:0]    idx_o
);

  logic [2*MASTER_COUNT-1:0] dbl;
  logic [MASTER_COUNT-1:0]   rot;
  logic                      found;
  int unsigned               start;
  int unsigned               off;
  int unsigned               sum;

  always_comb begin
    if (32'(last_i) >= MASTER_COUNT - 1) begin
      start = 0;
    end else begin
      start = 32'(last_i) + 1;
    end

    dbl = {eligible_i, eligible_i};
    rot = MASTER_COUNT'(dbl >> start);

    found = 1'b0;
    off   = 0;
    for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = i;
      end
    end

    sum = start + off;
    if (sum >= MASTER_COUNT) begin
      sum = sum - MASTER_COUNT;
    end

    valid_o = |eligible_i;
    idx_o   = GNT_WIDTH'(sum);
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin owner of the shared Wishbone path; holds the grant for the whole
// cycle and ends stalled cycles with a one-cycle timeout pulse plus a lockout.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned MASTER_COUNT   = 2,
  parameter int unsigned GNT_WIDTH      = $clog2(MASTER_COUNT),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [MASTER_COUNT-1:0] cyc_i,
  input  logic [MASTER_COUNT-1:0] stb_i,
  input  logic                    ack_i,
  input  logic                    err_i,
  input  logic                    rty_i,
  output logic [GNT_WIDTH-1:0]    gnt_o,
  output logic                    cyc_o,
  output logic                    timeout_o
);

  localparam int unsigned WdcWidth = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdcWidth-1:0] WdcLast =
      WdcWidth'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  wb_arb_state_t           state_q, state_d;
  logic [GNT_WIDTH-1:0]    gnt_q, gnt_d;
  logic [GNT_WIDTH-1:0]    last_q, last_d;
  logic [MASTER_COUNT-1:0] lock_q, lock_d;
  logic [WdcWidth-1:0]     wdc_q, wdc_d;

  logic [MASTER_COUNT-1:0] eligible;
  logic                    pick_valid;
  logic [GNT_WIDTH-1:0]    pick_idx;
  logic                    term;

  assign term = ack_i | err_i | rty_i;

  // The timed-out master is excluded already in the TIMEOUT cycle's re-pick.
  always_comb begin
    lock_d = lock_q & cyc_i;
    if (state_q == StTimeout) begin
      lock_d[gnt_q] = 1'b1;
    end
  end

  assign eligible = cyc_i & ~lock_d;

  wb_rr_pick #(
    .MASTER_COUNT(MASTER_COUNT),
    .GNT_WIDTH   (GNT_WIDTH)
  ) u_pick (
    .eligible_i(eligible),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wdc_d   = wdc_q;

    case (state_q)
      StIdle, StTimeout: begin
        if (pick_valid) begin
          state_d = StGranted;
          gnt_d   = pick_idx;
          last_d  = pick_idx;
          wdc_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StGranted: begin
        if (!cyc_i[gnt_q]) begin
          if (pick_valid) begin
            gnt_d  = pick_idx;
            last_d = pick_idx;
            wdc_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (term || !stb_i[gnt_q]) begin
            wdc_d = '0;
          end else if (wdc_q == WdcLast) begin
            state_d = StTimeout;
            wdc_d   = '0;
          end else begin
            wdc_d = wdc_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= GNT_WIDTH'(MASTER_COUNT - 1);
      lock_q  <= '0;
      wdc_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      wdc_q   <= wdc_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign cyc_o     = (state_q == StGranted) & cyc_i[gnt_q];
  assign timeout_o = (state_q == StTimeout);

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin bus arbiter that owns the shared Wishbone path of `wb_interconnect`. It decides which master drives the shared cycle, and holds that grant for the whole `cyc` assertion. A per-grant watchdog ends stalled cycles with a one-cycle timeout pulse, which the interconnect turns into `err` for the granted master. The timed-out master is then locked out until it releases `cyc`.

## Interface

Parameters:
- `MASTER_COUNT`, default 2: number of requesting masters, minimum 2.
- `GNT_WIDTH`, default `$clog2(MASTER_COUNT)`: width of the grant index.
- `TIMEOUT_CYCLES`, default 255: number of consecutive unterminated strobe cycles before a timeout. 0 disables the watchdog. Maximum 65535.

Ports:
- `clk_i`  in  1  sole clock; everything is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `cyc_i`  in  MASTER_COUNT  per-master cycle request.
- `stb_i`  in  MASTER_COUNT  per-master strobe; only used by the watchdog.
- `ack_i`  in  1  termination seen on the shared slave path.
- `err_i`  in  1  termination seen on the shared slave path.
- `rty_i`  in  1  termination seen on the shared slave path.
- `gnt_o`  out  GNT_WIDTH  registered index of the granted master.
- `cyc_o`  out  1  shared-bus cycle, gated by the grant.
- `timeout_o`  out  1  one-cycle pulse; the interconnect ORs it into `err` for the master selected by `gnt_o`.

## Operation

- State machine with three states: IDLE, GRANTED, TIMEOUT.
- Eligible master: `cyc_i[i]=1` and `lock[i]=0`.
- `lock[i]` clears in any cycle where `cyc_i[i]=0`.
- Round-robin pick: search starts at `last+1` and wraps modulo MASTER_COUNT. The first eligible master wins. `last` is the most recently granted index.
- IDLE to GRANTED:
  - Taken when any master is eligible.
  - `gnt_o` and `last` are loaded with the pick.
  - The watchdog counter `wdc` is cleared.
- GRANTED holds while `cyc_i[gnt_o]=1` and no timeout fires.
- Release, when `cyc_i[gnt_o]=0`:
  - If another master is eligible, re-pick and stay in GRANTED with the new `gnt_o`.
  - Otherwise go to IDLE.
- Watchdog, only when TIMEOUT_CYCLES≠0 and in GRANTED:
  - `ack_i|err_i|rty_i`, or `stb_i[gnt_o]=0`: `wdc` clears to 0.
  - Otherwise `wdc` increments.
  - If `wdc == TIMEOUT_CYCLES-1` while incrementing, go to TIMEOUT.
- TIMEOUT lasts exactly one cycle:
  - `timeout_o=1`, `cyc_o=0`.
  - `lock[gnt_o]` is set.
  - Next state is decided by the IDLE rule (the locked master is excluded).
- In IDLE, `gnt_o` keeps its last value, so the data multiplexers stay stable.
- Simultaneous events:
  - A termination in the expiry cycle takes priority: no timeout.
  - A release (`cyc_i` low) in the expiry cycle takes priority: no timeout.
  - `rst_i` takes priority over everything.

## Timing

- Reset values:
  - `gnt_o=0`, `cyc_o=0`, `timeout_o=0`, state IDLE.
  - `last=MASTER_COUNT-1`, so master 0 wins the first tie.
  - `lock=0`, `wdc=0`.
- Reset applied mid-cycle: outputs reach reset values at the edge where `rst_i` is sampled high. `cyc_o` drops in that same cycle.
- `cyc_o = (state==GRANTED) & cyc_i[gnt_o]`.
  - This is combinational from `cyc_i`, so `cyc_o` falls in the same cycle the master drops `cyc_i`.
- Grant latency: a request sampled in IDLE at edge N gives `gnt_o` valid and `cyc_o=1` from N+1.
- Handover: master A drops `cyc` in cycle M while B waits.
  - `cyc_o=0` in cycle M.
  - `gnt_o=B` and `cyc_o=1` from M+1.
  - This is the minimum one-cycle gap.
- Timeout: with `stb` high and no termination from grant cycle G, `timeout_o=1` in cycle G+TIMEOUT_CYCLES.
- `wdc` width is `$clog2(TIMEOUT_CYCLES+1)`. It never wraps, because it always leaves GRANTED at the limit.

## Structure

- Shared package `wb_arb_pkg`: the state enum `wb_arb_state_t` (IDLE, GRANTED, TIMEOUT).
- One combinational sub-module `wb_rr_pick`:
  - Inputs: eligible vector and `last`.
  - Outputs: `valid` and index.
  - Implemented as a rotate, then fixed-priority, then un-rotate.
- `wb_rr_arbiter` replaces the current `wb_arbiter` instance in `wb_interconnect`, with the port additions listed above.

## Test plan

- Reset, then `cyc_i=2'b11` held: `gnt_o=0` and `cyc_o=1` one cycle later. Master 0 drops `cyc` at cycle M: `cyc_o=0` in M, then `gnt_o=1` and `cyc_o=1` from M+1.
- MASTER_COUNT=4, all masters requesting, each releasing after 3 cycles: grant order 0,1,2,3,0 with no master skipped or repeated.
- TIMEOUT_CYCLES=4, master 1 alone, `stb` high, no `ack`:
  - `timeout_o=1` for exactly one cycle, at grant+4, with `cyc_o=0` in that cycle.
  - Master 1 is not re-granted while its `cyc` stays high.
  - After master 1 drops `cyc` for 1 cycle and reasserts, it is granted again.
- TIMEOUT_CYCLES=4 with `ack_i` pulsed every 3rd cycle, or with `ack_i` pulsed exactly in the expiry cycle: `timeout_o` never asserts.
- `rst_i` pulsed for one cycle while GRANTED with `gnt_o=1`: next cycle `gnt_o=0`, `cyc_o=0`, lock cleared. With both masters requesting, master 0 is granted one cycle after reset release.
- TIMEOUT_CYCLES=0: a master holds `stb` for 1000 cycles without `ack`; `timeout_o` stays 0 and the grant holds.
